mm_lsu: RTL and testbench

MM_LSU -- requirements
Module: mm_lsu

---
 rtl/mm_pkg.sv | 41 ++++
 rtl/mm_lsu_align.sv | 81 ++++++++
 rtl/mm_lsu.sv | 171 +++++++++++++++++
 tb/tb_mm_lsu.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg -- shared types and constants for the memory load/store unit.
//   mm_state_e  : LSU sequencer states
//   SZ_*        : size codes carried in mm_mem_e[3:2]
//   E_*         : bit positions inside the mm_mem_e control word
//   size_bytes  : access length in bytes for a size code
//   size_legal  : whether a size code is usable at the configured width
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } mm_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_D = 2'd2;
    localparam logic [1:0] SZ_W = 2'd3;

    localparam int E_VALID   = 4;
    localparam int E_SIZE_HI = 3;
    localparam int E_SIZE_LO = 2;
    localparam int E_ST      = 1;
    localparam int E_UNS     = 0;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Doubleword accesses only exist on a 64-bit datapath.
    function automatic logic size_legal(input logic [1:0] sz, input logic is_x64);
        return (sz != SZ_D) || is_x64;
    endfunction

endpackage

// File: rtl/mm_lsu_align.sv
// mm_lsu_align -- combinational access splitting, store shifting and load
// merge/extension for mm_lsu.
//   i_addr      : effective address of the access
//   i_size      : size code (SZ_*)
//   i_uns       : 1 = zero-extend loads, 0 = sign-extend
//   i_st_data   : store data as presented upstream
//   i_part0     : read data of the first access (low bytes)
//   i_part1     : read data of the second access (low bytes)
//   o_split     : access crosses a datapath-word boundary
//   o_cu0/o_cu1 : byte count minus one of the first/second access
//   o_addr1     : address of the second access
//   o_st_data1  : store data for the second access
//   o_ld_data   : merged, extended load result
module mm_lsu_align
    import mm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CUW  = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0] i_addr,
    input  logic [1:0]      i_size,
    input  logic            i_uns,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_part0,
    input  logic [XLEN-1:0] i_part1,
    output logic            o_split,
    output logic [CUW-1:0]  o_cu0,
    output logic [CUW-1:0]  o_cu1,
    output logic [XLEN-1:0] o_addr1,
    output logic [XLEN-1:0] o_st_data1,
    output logic [XLEN-1:0] o_ld_data
);

    localparam int         B  = XLEN/8;
    localparam int         OW = $clog2(B);
    localparam logic [4:0] B5 = 5'(B);

    logic [4:0]      w_off;
    logic [4:0]      w_n;
    logic [4:0]      w_l1;
    logic [4:0]      w_l2;
    logic [7:0]      w_sh;
    logic [XLEN-1:0] w_merge;
    logic            w_sign;

    assign w_off   = 5'(i_addr[OW-1:0]);
    assign w_n     = 5'(size_bytes(i_size));
    assign o_split = (w_off + w_n) > B5;

    // For an unsplit access L1 is the whole length, so the part1 term of the
    // merge lands entirely above the access and is removed by the extension.
    assign w_l1 = o_split ? (B5 - w_off) : w_n;
    assign w_l2 = w_n - w_l1;

    assign o_cu0      = CUW'(w_l1 - 5'd1);
    assign o_cu1      = CUW'(w_l2 - 5'd1);
    assign w_sh       = {w_l1, 3'b000};
    assign o_addr1    = i_addr + XLEN'(w_l1);
    assign o_st_data1 = i_st_data >> w_sh;
    assign w_merge    = i_part0 | (i_part1 << w_sh);

    always_comb begin
        case (i_size)
            SZ_B:    w_sign = w_merge[7];
            SZ_H:    w_sign = w_merge[15];
            SZ_W:    w_sign = w_merge[31];
            default: w_sign = w_merge[XLEN-1];
        endcase
    end

    // Every byte at or above N is replaced by the extension fill.
    always_comb begin
        o_ld_data = w_merge;
        for (int k = 0; k < B; k++) begin
            if (5'(k) >= w_n) begin
                o_ld_data[8*k +: 8] = {8{w_sign & ~i_uns}};
            end
        end
    end

endmodule

// File: rtl/mm_lsu.sv
// mm_lsu -- memory stage load/store unit. Non-memory ops pass straight to the
// writeback registers; memory ops are sequenced to the memory controller as
// one or two accesses (misaligned accesses are split at the word boundary).
//   clk, rst                 : clock, asynchronous active-low reset
//   we, wa, wn               : upstream writeback enable/register/value-or-address
//   mm_mem_n                 : store data
//   mm_mem_e                 : {valid, size[1:0], store, unsigned}
//   we_o, wa_o, wn_o         : registered writeback outputs
//   mm_mct_e/wr/a/cu/n_i     : controller request, write select, address,
//                              byte count minus one, write data
//   mm_mct_n_o, mm_mct_ok    : controller read data and completion pulse
//   stl                      : upstream stall
//   mm_err                   : one-cycle pulse on an illegal size code
module mm_lsu
    import mm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CUW  = $clog2(XLEN/8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wn,
    input  logic [XLEN-1:0] mm_mem_n,
    input  logic [4:0]      mm_mem_e,
    output logic            we_o,
    output logic [4:0]      wa_o,
    output logic [XLEN-1:0] wn_o,
    output logic [XLEN-1:0] mm_mct_a,
    output logic [XLEN-1:0] mm_mct_n_i,
    input  logic [XLEN-1:0] mm_mct_n_o,
    output logic            mm_mct_e,
    output logic            mm_mct_wr,
    output logic [CUW-1:0]  mm_mct_cu,
    input  logic            mm_mct_ok,
    output logic            stl,
    output logic            mm_err
);

    mm_state_e       r_state;
    logic            r_we_o;
    logic [4:0]      r_wa_o;
    logic [XLEN-1:0] r_wn_o;
    logic            r_err;

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_data;
    logic [1:0]      r_size;
    logic            r_st;
    logic            r_uns;
    logic            r_we;
    logic [4:0]      r_wa;
    logic [XLEN-1:0] r_part0;

    logic            w_legal;
    logic            w_start;
    logic            w_acc0;
    logic            w_acc1;
    logic            w_final;
    logic            w_split;
    logic [CUW-1:0]  w_cu0;
    logic [CUW-1:0]  w_cu1;
    logic [XLEN-1:0] w_addr1;
    logic [XLEN-1:0] w_st1;
    logic [XLEN-1:0] w_ld;
    logic [XLEN-1:0] w_part0;

    assign w_legal = size_legal(mm_mem_e[E_SIZE_HI:E_SIZE_LO], XLEN == 64);
    assign w_start = mm_mem_e[E_VALID] & w_legal;
    assign w_acc0  = (r_state == ST_ACC0);
    assign w_acc1  = (r_state == ST_ACC1);
    assign w_final = mm_mct_ok & ((w_acc0 & ~w_split) | w_acc1);

    // An unsplit access completes in ACC0, so its only part is the live read data.
    assign w_part0 = w_acc1 ? r_part0 : mm_mct_n_o;

    mm_lsu_align #(.XLEN(XLEN), .CUW(CUW)) u_align (
        .i_addr     (r_addr),
        .i_size     (r_size),
        .i_uns      (r_uns),
        .i_st_data  (r_data),
        .i_part0    (w_part0),
        .i_part1    (mm_mct_n_o),
        .o_split    (w_split),
        .o_cu0      (w_cu0),
        .o_cu1      (w_cu1),
        .o_addr1    (w_addr1),
        .o_st_data1 (w_st1),
        .o_ld_data  (w_ld)
    );

    // Controller side decodes only from state and latched operands, so it
    // falls to zero the instant reset forces the state back to IDLE.
    assign mm_mct_e   = w_acc0 | w_acc1;
    assign mm_mct_wr  = (w_acc0 | w_acc1) & r_st;
    assign mm_mct_a   = w_acc0 ? r_addr : (w_acc1 ? w_addr1 : '0);
    assign mm_mct_cu  = w_acc0 ? w_cu0  : (w_acc1 ? w_cu1   : '0);
    assign mm_mct_n_i = w_acc0 ? r_data : (w_acc1 ? w_st1   : '0);

    // The IDLE term looks at the upstream op so the stall covers the issue cycle.
    assign stl = w_acc0 | w_acc1 | (rst & (r_state == ST_IDLE) & w_start);

    assign we_o   = r_we_o;
    assign wa_o   = r_wa_o;
    assign wn_o   = r_wn_o;
    assign mm_err = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_we_o  <= 1'b0;
            r_wa_o  <= '0;
            r_wn_o  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!mm_mem_e[E_VALID]) begin
                        r_we_o <= we;
                        r_wa_o <= wa;
                        r_wn_o <= wn;
                    end else if (w_legal) begin
                        r_state <= ST_ACC0;
                        r_we_o  <= 1'b0;
                    end else begin
                        r_we_o <= 1'b0;
                        r_wa_o <= wa;
                        r_wn_o <= '0;
                        r_err  <= 1'b1;
                    end
                end
                ST_ACC0: begin
                    if (mm_mct_ok) begin
                        r_state <= w_split ? ST_ACC1 : ST_DONE;
                    end
                end
                ST_ACC1: begin
                    if (mm_mct_ok) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_final) begin
                r_we_o <= r_st ? 1'b0 : r_we;
                r_wa_o <= r_wa;
                r_wn_o <= r_st ? '0 : w_ld;
            end
        end
    end

    // Operand latches carry data only and need no reset.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && w_start) begin
            r_addr <= wn;
            r_data <= mm_mem_n;
            r_size <= mm_mem_e[E_SIZE_HI:E_SIZE_LO];
            r_st   <= mm_mem_e[E_ST];
            r_uns  <= mm_mem_e[E_UNS];
            r_we   <= we;
            r_wa   <= wa;
        end
        if (w_acc0 && mm_mct_ok) begin
            r_part0 <= mm_mct_n_o;
        end
    end

endmodule

// File: tb/tb_mm_lsu.sv
module tb_mm_lsu;

    typedef struct {
        bit        mem;
        bit [1:0]  size;
        bit        st;
        bit        uns;
        bit        we;
        bit [4:0]  wa;
        bit [31:0] wn;
        bit [31:0] data;
    } op_t;

    typedef struct {
        bit        is_mem;
        bit        we;
        bit [4:0]  wa;
        bit        chk_wa;
        bit [31:0] wn;
        bit        err;
    } exp_t;

    typedef struct {
        bit [31:0] a;
        int        cu;
        bit        wr;
        bit [31:0] d;
    } req_t;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wn;
    logic [31:0] mm_mem_n;
    logic [4:0]  mm_mem_e;
    logic        we_o;
    logic [4:0]  wa_o;
    logic [31:0] wn_o;
    logic [31:0] mm_mct_a;
    logic [31:0] mm_mct_n_i;
    logic [31:0] mm_mct_n_o;
    logic        mm_mct_e;
    logic        mm_mct_wr;
    logic [1:0]  mm_mct_cu;
    logic        mm_mct_ok;
    logic        stl;
    logic        mm_err;

    mm_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wa         (wa),
        .wn         (wn),
        .mm_mem_n   (mm_mem_n),
        .mm_mem_e   (mm_mem_e),
        .we_o       (we_o),
        .wa_o       (wa_o),
        .wn_o       (wn_o),
        .mm_mct_a   (mm_mct_a),
        .mm_mct_n_i (mm_mct_n_i),
        .mm_mct_n_o (mm_mct_n_o),
        .mm_mct_e   (mm_mct_e),
        .mm_mct_wr  (mm_mct_wr),
        .mm_mct_cu  (mm_mct_cu),
        .mm_mct_ok  (mm_mct_ok),
        .stl        (stl),
        .mm_err     (mm_err)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    req_t req_q[$];
    bit [7:0] ref_mem [256];
    bit [7:0] ctl_mem [256];
    bit   tb_live     = 0;
    bit   tb_rst_test = 0;
    int   forced_d    = -1;
    int   acc_cycles  = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic set_byte(input int a, input bit [7:0] v);
        ref_mem[a & 255] = v;
        ctl_mem[a & 255] = v;
    endtask

    // Reference model: expected controller requests and writeback, derived
    // from byte lengths, word offsets and a byte-array memory.
    task automatic model_push(input op_t op);
        exp_t e;
        int n, o, l1;
        bit [63:0] v;
        e = '{is_mem: 0, we: 0, wa: op.wa, chk_wa: 0, wn: 0, err: 0};
        if (!op.mem) begin
            e.we = op.we; e.chk_wa = 1; e.wn = op.wn;
        end else if (op.size == 2'd2) begin
            e.err = 1;
        end else begin
            n = (op.size == 0) ? 1 : (op.size == 1) ? 2 : 4;
            o = op.wn % 4;
            e.is_mem = 1;
            if (o + n <= 4) begin
                req_q.push_back('{a: op.wn, cu: n - 1, wr: op.st, d: op.data});
            end else begin
                l1 = 4 - o;
                req_q.push_back('{a: op.wn, cu: l1 - 1, wr: op.st, d: op.data});
                req_q.push_back('{a: op.wn + l1, cu: n - l1 - 1, wr: op.st, d: op.data >> (8 * l1)});
            end
            if (op.st) begin
                for (int i = 0; i < n; i++) ref_mem[(op.wn + i) & 255] = op.data[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v |= 64'(ref_mem[(op.wn + i) & 255]) << (8 * i);
                if (!op.uns && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 1);
                e.we = op.we; e.chk_wa = 1; e.wn = v[31:0];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input op_t op, input int fd);
        bit done;
        forced_d = fd;
        @(posedge clk); #1;
        we       = op.we;
        wa       = op.wa;
        wn       = op.wn;
        mm_mem_n = op.data;
        mm_mem_e = {op.mem, op.size, op.st, op.uns};
        tb_live  = 1;
        model_push(op);
        done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!stl) done = 1;
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
    endtask

    // Controller model: random wait per request, byte-array memory.
    initial begin
        bit   c_active;
        int   c_wait, c_d;
        req_t cur;
        bit [31:0] mask;
        c_active = 0; c_wait = 0; c_d = 0;
        cur = '{a: 0, cu: 0, wr: 0, d: 0};
        mm_mct_ok = 0; mm_mct_n_o = 0;
        forever begin
            @(negedge clk);
            mm_mct_ok = 0; mm_mct_n_o = 0;
            if (tb_rst_test) begin
                c_active = 0;
            end else if (mm_mct_e) begin
                if (!c_active) begin
                    if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                    else cur = req_q.pop_front();
                    c_active = 1; c_wait = 0;
                    c_d = (forced_d >= 0) ? forced_d : int'($urandom_range(0, 3));
                    acc_cycles += c_d + 1;
                end
                chk("req_addr", mm_mct_a, cur.a);
                chk("req_cu", 32'(mm_mct_cu), 32'(cur.cu));
                chk("req_wr", 32'(mm_mct_wr), 32'(cur.wr));
                if (cur.wr) begin
                    mask = (cur.cu == 3) ? 32'hFFFF_FFFF : ((32'd1 << (8 * (cur.cu + 1))) - 1);
                    chk("req_wdata", mm_mct_n_i & mask, cur.d & mask);
                end
                if (c_wait == c_d) begin
                    mm_mct_ok = 1;
                    for (int i = 0; i <= cur.cu; i++) begin
                        if (cur.wr) ctl_mem[(cur.a + i) & 255] = mm_mct_n_i[8*i +: 8];
                        else mm_mct_n_o[8*i +: 8] = ctl_mem[(cur.a + i) & 255];
                    end
                    c_active = 0;
                end else begin
                    c_wait++;
                end
            end
        end
    end

    // Monitor: an op retires in a non-stalled cycle; memory ops show their
    // writeback in that (DONE) cycle, other ops one edge later.
    initial begin
        bit   pend;
        exp_t pe, e;
        int   stall_cnt;
        pend = 0; stall_cnt = 0;
        pe = '{is_mem: 0, we: 0, wa: 0, chk_wa: 0, wn: 0, err: 0};
        forever begin
            @(negedge clk);
            if (tb_rst_test) begin
                pend = 0; stall_cnt = 0;
            end else begin
                if (pend) begin
                    chk("imm_we", 32'(we_o), 32'(pe.we));
                    if (pe.chk_wa) chk("imm_wa", 32'(wa_o), 32'(pe.wa));
                    chk("imm_wn", wn_o, pe.wn);
                    chk("imm_err", 32'(mm_err), 32'(pe.err));
                    pend = 0;
                end
                if (stl) begin
                    stall_cnt++;
                end else if (stall_cnt > 0 || tb_live) begin
                    if (exp_q.size() == 0) begin
                        chk("exp_underflow", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("op_kind", 32'(stall_cnt > 0), 32'(e.is_mem));
                        if (stall_cnt > 0) begin
                            chk("mem_we", 32'(we_o), 32'(e.we));
                            if (e.chk_wa) chk("mem_wa", 32'(wa_o), 32'(e.wa));
                            chk("mem_wn", wn_o, e.wn);
                            chk("mem_err", 32'(mm_err), 32'd0);
                            chk("stall_cycles", 32'(stall_cnt), 32'(1 + acc_cycles));
                        end else begin
                            pe = e; pend = 1;
                        end
                    end
                    stall_cnt = 0; acc_cycles = 0;
                end
            end
        end
    end

    initial begin
        op_t op;
        rst = 0; we = 0; wa = 0; wn = 0; mm_mem_n = 0; mm_mem_e = 0;
        for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom));
        #12;
        chk("rst_we_o", 32'(we_o), 32'd0);
        chk("rst_wn_o", wn_o, 32'd0);
        chk("rst_stl", 32'(stl), 32'd0);
        chk("rst_mct_e", 32'(mm_mct_e), 32'd0);
        chk("rst_err", 32'(mm_err), 32'd0);
        @(negedge clk); rst = 1;

        // Signed byte load, ok in the third ACC0 cycle.
        set_byte(8'h01, 8'h80);
        issue('{mem: 1, size: 0, st: 0, uns: 0, we: 1, wa: 5'd3, wn: 32'h1001, data: 0}, 2);
        // Split word load.
        set_byte(8'h03, 8'hAA); set_byte(8'h04, 8'hDD);
        set_byte(8'h05, 8'hBB); set_byte(8'h06, 8'hCC);
        issue('{mem: 1, size: 3, st: 0, uns: 0, we: 1, wa: 5'd9, wn: 32'h1003, data: 0}, -1);
        // Split halfword store.
        issue('{mem: 1, size: 1, st: 1, uns: 0, we: 1, wa: 5'd4, wn: 32'h1003, data: 32'h1234}, -1);
        // Illegal size on a 32-bit datapath.
        issue('{mem: 1, size: 2, st: 0, uns: 0, we: 1, wa: 5'd6, wn: 32'h1000, data: 0}, -1);
        // Zero-wait unsigned halfword load.
        set_byte(8'h00, 8'hFE); set_byte(8'h01, 8'hFF);
        issue('{mem: 1, size: 1, st: 0, uns: 1, we: 1, wa: 5'd2, wn: 32'h2000, data: 0}, 0);
        issue('{mem: 0, size: 0, st: 0, uns: 0, we: 1, wa: 5'd7, wn: 32'hDEAD_BEEF, data: 0}, -1);

        for (int k = 0; k < 300; k++) begin
            op.mem  = ($urandom_range(0, 9) < 7);
            op.size = 2'($urandom_range(0, 3));
            if (op.size == 2'd2 && $urandom_range(0, 3) != 0) op.size = 2'd3;
            op.st   = 1'($urandom);
            op.uns  = 1'($urandom);
            op.we   = 1'($urandom);
            op.wa   = 5'($urandom);
            op.data = $urandom;
            op.wn   = op.mem ? (32'h1000 + $urandom_range(0, 250)) : $urandom;
            issue(op, -1);
        end

        @(posedge clk); #1;
        mm_mem_e = 0; we = 0; tb_live = 0;
        repeat (3) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);

        // Reset in the middle of an access with the controller silent.
        tb_rst_test = 1;
        @(posedge clk); #1;
        we = 1; wa = 5'd1; wn = 32'h1000; mm_mem_e = 5'b1_11_0_0;
        @(posedge clk); #2;
        chk("acc0_mct_e", 32'(mm_mct_e), 32'd1);
        chk("acc0_stl", 32'(stl), 32'd1);
        rst = 0; #1;
        chk("midrst_mct_e", 32'(mm_mct_e), 32'd0);
        chk("midrst_stl", 32'(stl), 32'd0);
        chk("midrst_mct_a", mm_mct_a, 32'd0);
        chk("midrst_we_o", 32'(we_o), 32'd0);
        we = 1; wa = 5'd7; wn = 32'h5; mm_mem_e = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("post_rst_wn", wn_o, 32'h5);
        chk("post_rst_we", 32'(we_o), 32'd1);
        chk("post_rst_wa", 32'(wa_o), 32'd7);
        chk("post_rst_mct_e", 32'(mm_mct_e), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
